// File: rtl/stim_sequencer.sv
// stim_sequencer: writes a deterministic burst into each channel FIFO, drains them and checks the returned data
//   CLK, RESET (sync, active-low)           clock and reset
//   start, lfsr_mode, big_cfg               run request and per-run modes, latched on start
//   fifo_full, fifo_empty                   per-channel flow control, a set flag stalls the walk
//   rd_data, rd_valid                       read return, one cycle after the read strobe
//   init, write, wr_data, read, big         registered stimulus to the datapath
//   busy, done, err_count                   run status and saturating mismatch count
module stim_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH = 4,
   parameter int BURST_LEN = 4,
   parameter int INIT_CYCLES = 2,
   parameter logic [DATA_WIDTH-1:0] SEED = 'h0F
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  start,
   input  logic                  lfsr_mode,
   input  logic                  big_cfg,
   input  logic [NUM_CH-1:0]     fifo_full,
   input  logic [NUM_CH-1:0]     fifo_empty,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_valid,
   output logic                  init,
   output logic [NUM_CH-1:0]     write,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic [NUM_CH-1:0]     read,
   output logic                  big,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            err_count
);
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   typedef enum logic [2:0] {IDLE, INIT, WRITE, READ, DRAIN, DONE} state_t;
   state_t state, state_n, ph;
   logic [CW-1:0] ch, ch_n;
   logic [7:0] beat, beat_n, outstanding, out_n, err_n;
   logic [3:0] icnt, icnt_n;
   logic [DATA_WIDTH-1:0] wgen, wgen_n, egen, egen_n, wr_data_n;
   logic [NUM_CH-1:0] write_n, read_n;
   logic lfsr_q, lfsr_n, big_n, acc, last_beat, last_ch;

   function automatic logic [DATA_WIDTH-1:0] gen_next(input logic [DATA_WIDTH-1:0] v, input logic l);
      logic [31:0] x;
      logic fb;
      x = 32'(v);
      fb = DATA_WIDTH == 8  ? ^{x[7], x[5], x[4], x[3]} :
           DATA_WIDTH == 16 ? ^{x[15], x[14], x[12], x[3]} : ^{x[31], x[21], x[1], x[0]};
      return l ? {v[DATA_WIDTH-2:0], fb} : v + DATA_WIDTH'(1);
   endfunction

   assign last_beat = beat == 8'(BURST_LEN - 1);
   assign last_ch = ch == CW'(NUM_CH - 1);

   always_comb begin
      // the final INIT cycle already makes the first write decision so the strobe follows init without a gap
      ph = (state == INIT && icnt == 4'd0) ? WRITE : state;
      state_n = ph;
      ch_n = ch;
      beat_n = beat;
      icnt_n = icnt;
      wgen_n = wgen;
      egen_n = egen;
      wr_data_n = wr_data;
      lfsr_n = lfsr_q;
      big_n = big;
      write_n = '0;
      read_n = '0;
      err_n = err_count;
      out_n = outstanding;
      acc = 1'b0;
      if (rd_valid) begin
         // a return with nothing outstanding is an error but must not consume an expected word
         if (outstanding == 8'd0 || rd_data != egen)
            err_n = err_count == 8'hFF ? err_count : err_count + 8'd1;
         if (outstanding != 8'd0) begin
            egen_n = gen_next(egen, lfsr_q);
            out_n = outstanding - 8'd1;
         end
      end
      case (ph)
         IDLE, DONE: if (start) begin
            state_n = INIT;
            icnt_n = 4'(INIT_CYCLES - 1);
            lfsr_n = lfsr_mode;
            big_n = big_cfg;
            wgen_n = SEED;
            egen_n = SEED;
            err_n = '0;
         end
         INIT: icnt_n = icnt - 4'd1;
         WRITE: if (!fifo_full[ch]) begin
            write_n = NUM_CH'(1) << ch;
            wr_data_n = wgen;
            wgen_n = gen_next(wgen, lfsr_q);
            acc = 1'b1;
         end
         READ: if (!fifo_empty[ch]) begin
            read_n = NUM_CH'(1) << ch;
            out_n = out_n + 8'd1;
            acc = 1'b1;
         end
         DRAIN: if (out_n == 8'd0) state_n = DONE;
         default: ;
      endcase
      if (acc) begin
         beat_n = last_beat ? '0 : beat + 8'd1;
         ch_n = last_beat ? (last_ch ? '0 : ch + CW'(1)) : ch;
         if (last_beat && last_ch) state_n = ph == WRITE ? READ : DRAIN;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state <= IDLE;
         ch <= '0;
         beat <= '0;
         icnt <= '0;
         outstanding <= '0;
         wgen <= '0;
         egen <= '0;
         lfsr_q <= 1'b0;
         init <= 1'b0;
         write <= '0;
         wr_data <= '0;
         read <= '0;
         big <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         err_count <= '0;
      end else begin
         state <= state_n;
         ch <= ch_n;
         beat <= beat_n;
         icnt <= icnt_n;
         outstanding <= out_n;
         wgen <= wgen_n;
         egen <= egen_n;
         lfsr_q <= lfsr_n;
         init <= state_n == INIT;
         write <= write_n;
         wr_data <= wr_data_n;
         read <= read_n;
         big <= big_n;
         busy <= state_n inside {INIT, WRITE, READ, DRAIN};
         done <= state_n == DONE;
         err_count <= err_n;
      end
   end
endmodule
